// File: rtl/conv_lane_arbiter.sv
// conv_lane_arbiter: four per-lane byte FIFOs feeding one 8-to-32 converter.
// A lane holding a full word (4 bytes) is granted round-robin and streamed
// as exactly four contiguous bytes, so every converter word comes from one
// lane and stays 4-byte aligned.
// Optional feature: define CONV_ARB_OVF_EN to enable sticky overflow flags.
module conv_lane_arbiter #(
    parameter int DEPTH = 8
) (
    input  logic        clk_4f,
    input  logic        reset_L,
    input  logic [3:0]  push,
    input  logic [31:0] push_data,
    output logic [3:0]  full,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic [1:0]  out_lane,
    output logic        burst_start,
    output logic [3:0]  ovf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t           state_q;
    logic [1:0]       lane_q;
    logic [1:0]       rr_q;
    logic [1:0]       beat_q;
    logic [7:0]       out_data_q;
    logic             out_valid_q;
    logic [1:0]       out_lane_q;
    logic             burst_start_q;

    logic [7:0]       mem_q    [4][DEPTH];
    logic [PTR_W-1:0] wr_ptr_q [4];
    logic [PTR_W-1:0] rd_ptr_q [4];
    logic [CNT_W-1:0] cnt_q    [4];
    logic [CNT_W-1:0] cnt_d    [4];

    logic [3:0]       push_ok;
    logic [3:0]       pop;
    logic [3:0]       elig;
    logic             gnt_vld;
    logic [1:0]       gnt_lane;

    // Per-lane accept/pop strobes, next counts and eligibility; the lane
    // being popped this cycle is judged on the count it will have after the pop
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            full[i]    = (cnt_q[i] == CNT_W'(DEPTH));
            push_ok[i] = push[i] && !full[i];
            pop[i]     = (state_q == BURST) && (lane_q == 2'(i));
            cnt_d[i]   = cnt_q[i] + CNT_W'(push_ok[i]) - CNT_W'(pop[i]);
            elig[i]    = (cnt_q[i] - CNT_W'(pop[i])) >= CNT_W'(4);
        end
    end

    // Round-robin search starting at rr; the lowest offset that is eligible wins
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_lane = rr_q;
        for (int k = 3; k >= 0; k--) begin
            if (elig[rr_q + 2'(k)]) begin
                gnt_vld  = 1'b1;
                gnt_lane = rr_q + 2'(k);
            end
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk_4f) begin
        for (int i = 0; i < 4; i++) begin
            if (push_ok[i]) begin
                mem_q[i][wr_ptr_q[i]] <= push_data[8*i +: 8];
            end
        end
    end

    // FIFO pointers and occupancy counts
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < 4; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (push_ok[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PTR_W'(1);
                if (pop[i])     rd_ptr_q[i] <= rd_ptr_q[i] + PTR_W'(1);
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Burst FSM with registered converter-side outputs
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            state_q       <= IDLE;
            lane_q        <= 2'd0;
            rr_q          <= 2'd0;
            beat_q        <= 2'd0;
            out_data_q    <= 8'd0;
            out_valid_q   <= 1'b0;
            out_lane_q    <= 2'd0;
            burst_start_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    out_valid_q   <= 1'b0;
                    burst_start_q <= 1'b0;
                    if (gnt_vld) begin
                        state_q <= BURST;
                        lane_q  <= gnt_lane;
                        rr_q    <= gnt_lane + 2'd1;
                        beat_q  <= 2'd0;
                    end
                end
                BURST: begin
                    out_data_q    <= mem_q[lane_q][rd_ptr_q[lane_q]];
                    out_valid_q   <= 1'b1;
                    out_lane_q    <= lane_q;
                    burst_start_q <= (beat_q == 2'd0);
                    beat_q        <= beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        if (gnt_vld) begin
                            lane_q <= gnt_lane;
                            rr_q   <= gnt_lane + 2'd1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign out_lane    = out_lane_q;
    assign burst_start = burst_start_q;

`ifdef CONV_ARB_OVF_EN
    logic [3:0] ovf_q;

    // Sticky record of pushes dropped against a full lane
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            ovf_q <= 4'b0;
        end else begin
            ovf_q <= ovf_q | (push & full);
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 4'b0;
`endif

endmodule

// File: doc/conv_lane_arbiter.md
# conv_lane_arbiter

Round-robin scheduler that shares the single 8-to-32 byte-to-word converter among four byte-stream lanes.

- Each lane writes bytes into a private FIFO.
- When a lane holds a complete word (4 bytes), the arbiter grants it and streams exactly 4 contiguous bytes, first-written first, onto the converter's `in_data`/`in` inputs.
- Every converter word is therefore built from a single lane and stays 4-byte aligned.
- The block sits directly upstream of the converter in the `clk_4f` domain.

## Interface

Parameters:
- `DEPTH`, default 8: per-lane FIFO depth in bytes. Must be a power of 2 and ≥ 4.

Ports:
- `clk_4f` input 1: byte clock. All logic is on the rising edge.
- `reset_L` input 1: asynchronous, active-low reset.
- `push` input 4: per-lane byte write strobes; bit i is lane i.
- `push_data` input 32: lane i byte is `push_data[8i+7:8i]`.
- `full` output 4: lane FIFO full (count == DEPTH). Driven from registered count.
- `out_data` output 8: byte to converter `in_data`. Registered.
- `out_valid` output 1: to converter `in`. Registered.
- `out_lane` output 2: lane owning the current burst. Registered.
- `burst_start` output 1: high on the first byte of each burst. Registered.
- `ovf` output 4: sticky overflow flags (see Configuration).

## Operation

- Per-lane FIFO: DEPTH entries, read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH, and a count of log2(DEPTH)+1 bits.
- A push with `full[i]=1` is dropped, even if lane i pops in the same cycle.
- Push and pop on the same lane in the same cycle: both are honoured, count is unchanged.
- Eligibility: lane i is eligible when `count[i] ≥ 4`. A push in cycle N affects eligibility from N+1.
- Round-robin pointer `rr` (2 bits, reset 0):
  - The search order is `rr`, `rr+1`, … mod 4.
  - On a grant to lane g, `rr` becomes `g+1` mod 4.
- FSM states:
  - **IDLE**
    - `out_valid=0`.
    - If any lane is eligible: grant it, go to BURST with `beat=0`.
    - Else stay in IDLE.
  - **BURST**
    - Each cycle: pop one byte from the granted lane into `out_data`, set `out_valid=1`, then increment `beat`.
    - At `beat==3` (last pop), re-arbitrate. The active lane's eligibility uses `count-1`; all other lanes use their current count.
    - If a lane is eligible: grant it and stay in BURST with `beat=0`, giving back-to-back bursts with no gap.
    - Else go to IDLE.
- A burst is never truncated. It is always exactly 4 bytes, because eligibility guarantees 4 bytes are resident.
- `out_lane` and `burst_start` update together with the first byte. `out_lane` holds its value while idle.
- Reset (asynchronous, any state including mid-burst):
  - FIFOs are emptied; state goes to IDLE; `rr=0`, `beat=0`.
  - Outputs: `out_valid=0`, `out_data=0`, `out_lane=0`, `burst_start=0`, `full=0`, `ovf=0`.
  - A partially delivered word is abandoned. The converter is reset alongside and discards it.

## Timing

- Push-to-output: the 4th byte of lane i is pushed at edge N.
  - The IDLE grant decision is made in cycle N+1.
  - The first byte is on `out_data` with `out_valid=1` after edge N+2.
  - The last byte is out after edge N+5.
- Burst length: 4 consecutive `clk_4f` cycles. The converter sees one word per burst, i.e. one `clk_f` period per burst at full rate.
- Back-to-back bursts: `out_valid` stays continuously high. `burst_start` pulses every 4th cycle.
- Gap: when no lane is eligible after a burst, `out_valid` drops the cycle after the last byte.
- `full` deasserts the cycle after the pop that frees a slot.

## Configuration

- `CONV_ARB_OVF_EN` defined:
  - `ovf[i]` sets when a push to lane i is dropped because the lane is full.
  - The flag stays set until `reset_L` is asserted.
- Not defined:
  - Overflow detection logic is absent and `ovf` is tied to 4'b0.
  - Dropped pushes are silently lost.

## Test plan

- **Single lane:** push 0xA1, 0xB2, 0xC3, 0xD4 on lane 2, one per cycle.
  - Expect `out_data` A1, B2, C3, D4 on 4 consecutive cycles.
  - Expect `out_valid=1` and `out_lane=2`; `burst_start` high only on A1.
  - First byte appears 2 cycles after the D4 push.
- **Round-robin:** preload all 4 lanes with 4 bytes each (lane i bytes = 0x10·i+0..3), then release from reset-idle.
  - Bursts run in lane order 0, 1, 2, 3 back-to-back: 16 cycles of continuous `out_valid`.
  - `rr` ends at 0.
- **Fairness:** lanes 1 and 3 refilled continuously.
  - Grants alternate 1, 3, 1, 3; lane 3 is never granted twice in a row.
- **Fill and overflow:** push 9 bytes to lane 0 with DEPTH=8 and no pops.
  - `full[0]=1` after the 8th push; the 9th byte is dropped.
  - With `CONV_ARB_OVF_EN`: `ovf[0]=1`. Without it: `ovf=0`.
  - The next two bursts output only the first 8 bytes.
- **Pointer wrap:** push 3 bytes, then 1 byte; drain; repeat until pointers wrap ≥ 3 times.
  - Byte order is preserved across the wrap.
- **Reset mid-burst:** drop `reset_L` after the 2nd byte of a lane-1 burst.
  - `out_valid` goes to 0 immediately and all outputs clear.
  - After release with no pushes, `out_valid` stays 0.
